// File: rtl/exe_stage.sv
// exe_stage: execute stage of the 5-stage ARM pipeline.
//
// Consumes the ID/EXE register outputs. It builds the second ALU operand
// (Val2), runs the ALU and computes the branch target. It also owns the
// NZCV status register that feeds the condition check in ID. Results are
// captured in an internal EXE/MEM bank, so they appear one cycle after
// the instruction is presented.
//
// Optional feature: define EXE_FWD_EN to select operands through the
// forwarding muxes (sel_src1/sel_src2 choosing ID value, fwd_mem_val or
// fwd_wb_val). Without it, sel_src*/fwd_* are ignored.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   freeze              memory stall: EXE/MEM bank and status hold
//   wb_en_in, mem_r_en_in, mem_w_en_in, exe_cmd_in, b_in, s_in, imm_in,
//   pc_in, value_rn_in, value_rm_in, shift_operand_in, imm_signed_24_in,
//   dest_in             instruction fields from ID/EXE
//   sel_src1, sel_src2, fwd_mem_val, fwd_wb_val   forwarding inputs
//   branch_taken, branch_address   combinational branch outputs
//   status              registered NZCV ({N,Z,C,V})
//   wb_en, mem_r_en, mem_w_en, alu_result, st_value, dest   EXE/MEM bank
//
// Flow control: there is no valid/ready pair. freeze=1 is a stall. While
// it is high, the bank and status keep their values. Upstream must keep
// its inputs stable until freeze drops.

module exe_stage #(
  parameter logic [3:0] STATUS_RST = 4'b0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic [3:0]  exe_cmd_in,
  input  logic        b_in,
  input  logic        s_in,
  input  logic        imm_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] value_rn_in,
  input  logic [31:0] value_rm_in,
  input  logic [11:0] shift_operand_in,
  input  logic [23:0] imm_signed_24_in,
  input  logic [3:0]  dest_in,
  input  logic [1:0]  sel_src1,
  input  logic [1:0]  sel_src2,
  input  logic [31:0] fwd_mem_val,
  input  logic [31:0] fwd_wb_val,
  output logic        branch_taken,
  output logic [31:0] branch_address,
  output logic [3:0]  status,
  output logic        wb_en,
  output logic        mem_r_en,
  output logic        mem_w_en,
  output logic [31:0] alu_result,
  output logic [31:0] st_value,
  output logic [3:0]  dest
);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  logic [31:0] op_rn;
  logic [31:0] op_rm;

  // ---------------- operand selection ----------------
`ifdef EXE_FWD_EN
  // Code 11 is unused by the hazard unit and falls back to the ID value.
  always_comb begin
    case (sel_src1)
      2'b01:   op_rn = fwd_mem_val;
      2'b10:   op_rn = fwd_wb_val;
      default: op_rn = value_rn_in;
    endcase
  end

  always_comb begin
    case (sel_src2)
      2'b01:   op_rm = fwd_mem_val;
      2'b10:   op_rm = fwd_wb_val;
      default: op_rm = value_rm_in;
    endcase
  end
`else
  assign op_rn = value_rn_in;
  assign op_rm = value_rm_in;

  logic unused_fwd;
  assign unused_fwd = ^{sel_src1, sel_src2, fwd_mem_val, fwd_wb_val};
`endif

  // ---------------- Val2 generation ----------------
  logic [31:0] imm32;
  logic [4:0]  rot_amt;
  logic [31:0] imm_rot;
  logic [4:0]  sh_amt;
  logic [31:0] rm_shifted;
  logic [31:0] val2;

  assign imm32   = {24'd0, shift_operand_in[7:0]};
  assign rot_amt = {shift_operand_in[11:8], 1'b0};
  // A left shift by 32 yields 0, so a rotate by 0 returns imm32 unchanged.
  assign imm_rot = (imm32 >> rot_amt) | (imm32 << (6'd32 - {1'b0, rot_amt}));
  assign sh_amt  = shift_operand_in[11:7];

  always_comb begin
    rm_shifted = op_rm;
    case (shift_operand_in[6:5])
      2'b00: rm_shifted = op_rm << sh_amt;
      2'b01: rm_shifted = op_rm >> sh_amt;
      2'b10: rm_shifted = $signed(op_rm) >>> sh_amt;
      2'b11: rm_shifted = (op_rm >> sh_amt) | (op_rm << (6'd32 - {1'b0, sh_amt}));
      default: rm_shifted = op_rm;
    endcase
  end

  always_comb begin
    if (mem_r_en_in || mem_w_en_in) val2 = {20'd0, shift_operand_in};
    else if (imm_in)                val2 = imm_rot;
    else                            val2 = rm_shifted;
  end

  // ---------------- ALU ----------------
  // The add and subtract commands share one 33-bit adder. A subtract
  // becomes Rn + ~Val2 + cin, so the carry out is the ARM not-borrow.
  logic        is_sub;
  logic        add_cin;
  logic [31:0] add_b;
  logic [32:0] sum;
  logic        add_v;

  assign is_sub = (exe_cmd_in == CMD_SUB) || (exe_cmd_in == CMD_SBC);
  assign add_b  = is_sub ? ~val2 : val2;

  always_comb begin
    case (exe_cmd_in)
      CMD_SUB:          add_cin = 1'b1;
      CMD_ADC, CMD_SBC: add_cin = status[1];
      default:          add_cin = 1'b0;
    endcase
  end

  assign sum   = {1'b0, op_rn} + {1'b0, add_b} + {32'd0, add_cin};
  assign add_v = (op_rn[31] == add_b[31]) && (sum[31] != op_rn[31]);

  logic [31:0] alu_res;
  logic        n_next;
  logic        z_next;
  logic        c_next;
  logic        v_next;

  always_comb begin
    alu_res = 32'd0;
    c_next  = status[1];
    v_next  = status[0];
    case (exe_cmd_in)
      CMD_MOV: alu_res = val2;
      CMD_MVN: alu_res = ~val2;
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
        alu_res = sum[31:0];
        c_next  = sum[32];
        v_next  = add_v;
      end
      CMD_AND: alu_res = op_rn & val2;
      CMD_ORR: alu_res = op_rn | val2;
      CMD_EOR: alu_res = op_rn ^ val2;
      default: alu_res = 32'd0;
    endcase
    n_next = alu_res[31];
    z_next = (alu_res == 32'd0);
  end

  // ---------------- branch ----------------
  assign branch_taken   = b_in;
  assign branch_address = pc_in + {{6{imm_signed_24_in[23]}}, imm_signed_24_in, 2'b00};

  // ---------------- status register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 status <= STATUS_RST;
    else if (s_in && !freeze) status <= {n_next, z_next, c_next, v_next};
  end

  // ---------------- EXE/MEM bank ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en      <= 1'b0;
      mem_r_en   <= 1'b0;
      mem_w_en   <= 1'b0;
      alu_result <= 32'd0;
      st_value   <= 32'd0;
      dest       <= 4'd0;
    end else if (!freeze) begin
      wb_en      <= wb_en_in;
      mem_r_en   <= mem_r_en_in;
      mem_w_en   <= mem_w_en_in;
      alu_result <= alu_res;
      st_value   <= op_rm;
      dest       <= dest_in;
    end
  end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage ARM pipeline; consumes the ID/EXE register outputs.
- Computes Val2 (immediate rotate, register shift, or memory offset), runs the ALU, and computes the branch target.
- Holds the NZCV status register, which feeds condition check in ID.
- Registers results into an internal EXE/MEM bank, so outputs appear one cycle later.

Parameters:
- STATUS_RST, 4'b0000, NZCV value loaded on reset ({N,Z,C,V}).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- freeze  input  1  memory stall; holds the EXE/MEM bank and the status register.
- wb_en_in, mem_r_en_in, mem_w_en_in  input  1 each  control bits from ID/EXE.
- exe_cmd_in  input  4  ALU command.
- b_in, s_in, imm_in  input  1 each  branch, set-flags, immediate select.
- pc_in  input  32  PC+4 of the instruction.
- value_rn_in, value_rm_in  input  32 each  operands.
- shift_operand_in  input  12  shifter operand / offset.
- imm_signed_24_in  input  24  branch offset.
- dest_in  input  4  destination register.
- sel_src1, sel_src2  input  2 each  forward selects; used only with EXE_FWD_EN.
- fwd_mem_val, fwd_wb_val  input  32 each  forward data; used only with EXE_FWD_EN.
- branch_taken  output  1  combinational, equals b_in; also the flush to IF/ID.
- branch_address  output  32  combinational target address.
- status  output  4  registered NZCV, to ID.
- wb_en, mem_r_en, mem_w_en  output  1 each  registered controls.
- alu_result  output  32  registered ALU result.
- st_value  output  32  registered store data (the effective Rm value).
- dest  output  4  registered destination register.

Behaviour:
- Reset (rst=0, asynchronous): all registered outputs go to 0; status goes to STATUS_RST. Reset wins over freeze. Reset asserted mid-operation discards the in-flight instruction.
- Latency: inputs at edge k appear on the registered outputs after edge k+1. branch_taken and branch_address are same-cycle combinational.
- freeze=1: bank and status hold; branch_taken still follows b_in. Upstream must hold its inputs while frozen.
- Val2 selection:
  - mem_r_en_in|mem_w_en_in: Val2 = zero-extended shift_operand_in.
  - Otherwise imm_in=1: {24'b0, so[7:0]} rotated right by 2*so[11:8].
  - Otherwise: Rm shifted by so[11:7] using so[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. A shift amount of 0 passes Rm unchanged.
- ALU commands (exe_cmd_in): 0001 MOV, 1001 MVN (~Val2), 0010 ADD, 0011 ADC (Rn+Val2+C), 0100 SUB, 0101 SBC (Rn-Val2-!C), 0110 AND, 0111 ORR, 1000 EOR. Loads, stores, CMP and TST reuse ADD, SUB and AND. Unlisted codes give result 0, flags N=0 Z=1, C and V held.
- Flags:
  - N = result[31]; Z = (result==0).
  - ADD/ADC: C = carry out of the 33-bit sum.
  - SUB/SBC: computed as Rn+~Val2+cin with cin 1 or C; C = carry out, i.e. not-borrow.
  - V = signed overflow for add/sub.
  - Logical ops and MOV/MVN keep C and V.
- Status write: at the clock edge when s_in=1 and freeze=0. ADC and SBC use the current registered C.
- Branch address: pc_in + {{6{imm24[23]}}, imm24, 2'b00}, 32-bit wrap.
- Store data: st_value = effective Rm, including any forwarding.
- Flush of younger stages is the caller's job via branch_taken. This block's bank latches branches with wb_en=0 as supplied.

Optional Feature:
- Macro: EXE_FWD_EN.
- Defined: operand sources select by sel_src* (ID value, fwd_mem_val, fwd_wb_val for 00, 01, 10); code 11 acts as 00.
- Undefined: sel_src* and fwd_* are ignored; operands come from value_rn_in and value_rm_in.

Test Plan:
- Reset to 0 while freeze=1 -> all outputs 0 and status=STATUS_RST; release rst -> ADD Rn=5, shift_operand=0x007 with imm=1 -> alu_result=12 one cycle later.
- SUB, s=1, Rn=3, Val2=5 -> alu_result=0xFFFFFFFE, status NZCV=1000. Next ADC, Rn=1, Val2=1 -> result=2, carry-in 0 used.
- MOV imm=1, shift_operand=0x4FF -> 0xFF000000. MOV imm=0, Rm=0x80000000, so=0x0240 (ASR #4) -> 0xF8000000.
- B with pc_in=0x100, imm24=0xFFFFFE -> branch_taken=1 same cycle, branch_address=0x000000F8; status unchanged.
- freeze=1 for 3 cycles with a changing SUB s=1 on the inputs -> alu_result and status held; they update on the first edge after freeze=0.
- With EXE_FWD_EN: sel_src1=01, fwd_mem_val=10, value_rn_in=99, ADD imm 1 -> 11. sel_src2=10 with fwd_wb_val=0x55 on STR -> st_value=0x55.
